// File: rtl/ti_share_refresh_reg_pkg.sv
// ---------------------------------------------------------------------------
// ti_share_refresh_reg_pkg
// Shared constants and types for the 4-share threshold-implementation
// GF(2^4) inversion datapath:
//   - share width / share count
//   - 16-bit Fibonacci LFSR width, taps, default init and next-state helper
//   - encoding of the 2-entry skid buffer state
// ---------------------------------------------------------------------------
package ti_share_refresh_reg_pkg;

    localparam int SHARE_W = 4;
    localparam int SHARE_N = 4;

    localparam int LFSR_W = 16;
    // Tap positions (1-based polynomial terms x^16 + x^14 + x^13 + x^11)
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;
    localparam logic [LFSR_W-1:0] LFSR_INIT_DEFAULT = 16'hACE1;

    // Number of LFSR bits consumed as refresh randomness (three masks)
    localparam int RAND_W = (SHARE_N - 1) * SHARE_W;

    typedef logic [SHARE_N-1:0][SHARE_W-1:0] shares_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B] ^ l[LFSR_TAP_C] ^ l[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/ti_lfsr16.sv
// ---------------------------------------------------------------------------
// ti_lfsr16
// 16-bit Fibonacci LFSR that supplies refresh randomness. Steps every cycle
// out of reset; a seed load replaces the step, with an all-zero seed mapped
// to 16'h0001 so the register can never lock up.
// Ports:
//   clk       clock
//   srst      synchronous active-high reset (loads INIT, ignores seed load)
//   seed_ld   load seed instead of stepping
//   seed      reseed value
//   rand_o    low 12 bits of the current LFSR value (three 4-bit masks)
// ---------------------------------------------------------------------------
module ti_lfsr16
    import ti_share_refresh_reg_pkg::*;
#(
    parameter logic [LFSR_W-1:0] INIT = LFSR_INIT_DEFAULT
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              seed_ld,
    input  logic [LFSR_W-1:0] seed,
    output logic [RAND_W-1:0] rand_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        if (seed_ld) begin
            lfsr_d = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            lfsr_q <= INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_o = lfsr_q[RAND_W-1:0];

endmodule

// File: rtl/ti_share_refresh_reg.sv
// ---------------------------------------------------------------------------
// ti_share_refresh_reg
// Registered share-refresh stage in front of the first shared GF(2^4)
// inverter. Fresh LFSR masks are XORed into a 4-share nibble on accept (the
// fourth share absorbs all three masks so the unmasked value is unchanged),
// and the refreshed beat is held in a 2-entry skid buffer behind
// valid/ready handshakes. Every output is a flop.
// Ports:
//   ClkxCI / RstxRI        clock, synchronous active-high reset
//   XxDI0..3, ValidxSI     input shares and valid; ReadyxSO (registered)
//   QxDO0..3, ValidxSO     refreshed output shares and valid; ReadyxSI
//   SeedxDI, SeedLdxSI     LFSR reseed value and load strobe
// ---------------------------------------------------------------------------
module ti_share_refresh_reg
    import ti_share_refresh_reg_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_INIT = LFSR_INIT_DEFAULT
) (
    input  logic               ClkxCI,
    input  logic               RstxRI,
    input  logic [SHARE_W-1:0] XxDI0,
    input  logic [SHARE_W-1:0] XxDI1,
    input  logic [SHARE_W-1:0] XxDI2,
    input  logic [SHARE_W-1:0] XxDI3,
    input  logic               ValidxSI,
    output logic               ReadyxSO,
    output logic [SHARE_W-1:0] QxDO0,
    output logic [SHARE_W-1:0] QxDO1,
    output logic [SHARE_W-1:0] QxDO2,
    output logic [SHARE_W-1:0] QxDO3,
    output logic               ValidxSO,
    input  logic               ReadyxSI,
    input  logic [LFSR_W-1:0]  SeedxDI,
    input  logic               SeedLdxSI
);

    logic [RAND_W-1:0] rand_bits;
    shares_t           x_in;
    shares_t           x_refr;
    logic [SHARE_W-1:0] mask_sum;

    buf_state_t state_q, state_d;
    shares_t    main_q, main_d;
    shares_t    skid_q, skid_d;
    logic       valid_q, valid_d;
    logic       ready_q, ready_d;

    logic accept;
    logic emit;

    ti_lfsr16 #(
        .INIT (LFSR_INIT)
    ) u_lfsr (
        .clk     (ClkxCI),
        .srst    (RstxRI),
        .seed_ld (SeedLdxSI),
        .seed    (SeedxDI),
        .rand_o  (rand_bits)
    );

    assign x_in = {XxDI3, XxDI2, XxDI1, XxDI0};

    // Shares 0..2 each take their own mask; the last share takes the XOR of
    // all masks so the sum over shares is preserved.
    generate
        for (genvar gi = 0; gi < SHARE_N - 1; gi++) begin : g_refresh
            assign x_refr[gi] = x_in[gi] ^ rand_bits[gi*SHARE_W +: SHARE_W];
        end
    endgenerate

    assign mask_sum = rand_bits[0 +: SHARE_W]
                    ^ rand_bits[SHARE_W +: SHARE_W]
                    ^ rand_bits[2*SHARE_W +: SHARE_W];
    assign x_refr[SHARE_N-1] = x_in[SHARE_N-1] ^ mask_sum;

    assign accept = ValidxSI & ready_q;
    assign emit   = valid_q & ReadyxSI;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    main_d  = x_refr;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && emit) begin
                    main_d = x_refr;
                end else if (accept) begin
                    skid_d  = x_refr;
                    state_d = BUF_TWO;
                end else if (emit) begin
                    // main keeps its last value; ValidxSO marks it stale
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (emit) begin
                    main_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
        // Handshake outputs are derived from the next state so they can be
        // registered without a combinational path from ReadyxSI/ValidxSI.
        valid_d = (state_d != BUF_EMPTY);
        ready_d = (state_d != BUF_TWO);
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign QxDO0    = main_q[0];
    assign QxDO1    = main_q[1];
    assign QxDO2    = main_q[2];
    assign QxDO3    = main_q[3];
    assign ValidxSO = valid_q;
    assign ReadyxSO = ready_q;

endmodule
